// File: rtl/usb_rx_decoder.sv
// USB receive line decoder: synchronizer, bit-timing recovery, SYNC detect, NRZI decode, unstuffing, EOP/error.
// Optional bus-reset (long SE0) detector enabled by defining USB_RX_BUS_RESET_DET_EN.
module usb_rx_decoder #(
    parameter int FULLSPEED    = 1,
    parameter int CLKS_PER_BIT = 4,
    parameter int RESET_CLKS   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       linep,
    input  logic       linem,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_error
`ifdef USB_RX_BUS_RESET_DET_EN
    ,
    output logic       bus_reset
`endif
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {CLS_SE0, CLS_J, CLS_K, CLS_SE1} line_cls_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERR} state_t;

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || RESET_CLKS < 1) begin : g_bad_cfg
        $error("usb_rx_decoder: CLKS_PER_BIT must be even and >= 4, RESET_CLKS >= 1");
    end

    logic r_p_meta, r_p_sync, r_m_meta, r_m_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_meta <= 1'b0;
            r_p_sync <= 1'b0;
            r_m_meta <= 1'b0;
            r_m_sync <= 1'b0;
        end else begin
            r_p_meta <= linep;
            r_p_sync <= r_p_meta;
            r_m_meta <= linem;
            r_m_sync <= r_m_meta;
        end
    end

    assign line_state = {r_m_sync, r_p_sync};

    line_cls_t w_cls;

    always_comb begin
        case (line_state)
            2'b00:   w_cls = CLS_SE0;
            2'b11:   w_cls = CLS_SE1;
            2'b01:   w_cls = (FULLSPEED != 0) ? CLS_J : CLS_K;
            default: w_cls = (FULLSPEED != 0) ? CLS_K : CLS_J;
        endcase
    end

    // Phase restarts at 1 on every class change, so the sample lands mid-bit.
    logic [PW-1:0] r_phase;
    line_cls_t     r_cls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            r_cls   <= CLS_SE0;
        end else begin
            r_cls <= w_cls;
            if (w_cls != r_cls) begin
                r_phase <= PW'(1);
            end else if (r_phase == PHASE_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    logic w_sample, w_is_jk, w_bit;

    assign w_sample = (r_phase == PHASE_MID);
    assign w_is_jk  = (r_cls == CLS_J) || (r_cls == CLS_K);

`ifdef USB_RX_BUS_RESET_DET_EN
    localparam int RW = $clog2(RESET_CLKS + 1);
    logic [RW-1:0] r_se0_cnt;
    logic          w_bus_reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_se0_cnt <= '0;
        end else if (line_state == 2'b00) begin
            if (r_se0_cnt != RW'(RESET_CLKS)) r_se0_cnt <= r_se0_cnt + RW'(1);
        end else begin
            r_se0_cnt <= '0;
        end
    end

    assign w_bus_reset = (r_se0_cnt == RW'(RESET_CLKS));
    assign bus_reset   = w_bus_reset;
`endif

    state_t    r_state, w_state_nxt;
    line_cls_t r_prev_jk, w_prev_nxt;
    logic [2:0] r_zeros, w_zeros_nxt;
    logic [2:0] r_ones, w_ones_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic r_misalign, w_misalign_nxt;
    logic r_j_seen, w_j_seen_nxt;
    logic r_active, w_active_nxt;
    logic r_valid, w_valid_nxt;
    logic r_eop, w_eop_nxt;
    logic r_error, w_error_nxt;
    logic w_keep, w_fail;

    assign w_bit = (r_cls == r_prev_jk);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_prev_jk  <= CLS_J;
            r_zeros    <= '0;
            r_ones     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
            r_j_seen   <= 1'b0;
            r_active   <= 1'b0;
            r_valid    <= 1'b0;
            r_eop      <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_jk  <= w_prev_nxt;
            r_zeros    <= w_zeros_nxt;
            r_ones     <= w_ones_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_misalign <= w_misalign_nxt;
            r_j_seen   <= w_j_seen_nxt;
            r_active   <= w_active_nxt;
            r_valid    <= w_valid_nxt;
            r_eop      <= w_eop_nxt;
            r_error    <= w_error_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev_jk;
        w_zeros_nxt    = r_zeros;
        w_ones_nxt     = r_ones;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_data_nxt     = r_data;
        w_misalign_nxt = r_misalign;
        w_j_seen_nxt   = r_j_seen;
        w_active_nxt   = r_active;
        w_valid_nxt    = 1'b0;
        w_eop_nxt      = 1'b0;
        w_error_nxt    = 1'b0;
        w_keep         = 1'b0;
        w_fail         = 1'b0;

        if (w_sample) begin
            if (w_is_jk) w_prev_nxt = r_cls;
            case (r_state)
                ST_IDLE: begin
                    if (r_cls == CLS_K) begin
                        w_state_nxt = ST_SYNC;
                        w_zeros_nxt = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!w_is_jk) begin
                        w_fail = 1'b1;
                    end else if (!w_bit) begin
                        if (r_zeros != 3'd7) w_zeros_nxt = r_zeros + 3'd1;
                    end else if (r_zeros >= 3'd3) begin
                        w_state_nxt   = ST_DATA;
                        w_active_nxt  = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_ones_nxt    = 3'd1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cls == CLS_SE0) begin
                        w_state_nxt    = ST_EOP;
                        w_misalign_nxt = (r_bit_cnt != 3'd0);
                    end else if (r_cls == CLS_SE1) begin
                        w_fail = 1'b1;
                    end else if (w_bit) begin
                        if (r_ones == 3'd6) begin
                            w_fail = 1'b1;
                        end else begin
                            w_ones_nxt = r_ones + 3'd1;
                            w_keep     = 1'b1;
                        end
                    end else begin
                        // A 0 after six 1s is a stuff bit and is dropped.
                        w_ones_nxt = '0;
                        w_keep     = (r_ones != 3'd6);
                    end
                end
                ST_EOP: begin
                    if (r_cls == CLS_J) begin
                        w_eop_nxt    = !r_misalign;
                        w_error_nxt  = r_misalign;
                        w_active_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else if (r_cls != CLS_SE0) begin
                        w_fail = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (r_cls == CLS_J) begin
                        if (r_j_seen) w_state_nxt = ST_IDLE;
                        w_j_seen_nxt = 1'b1;
                    end else begin
                        w_j_seen_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_keep) begin
            w_shift_nxt = {w_bit, r_shift[6:1]};
            if (r_bit_cnt == 3'd7) begin
                w_data_nxt    = {w_bit, r_shift};
                w_valid_nxt   = 1'b1;
                w_bit_cnt_nxt = '0;
            end else begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
        end

        if (w_fail) begin
            w_state_nxt  = ST_ERR;
            w_active_nxt = 1'b0;
            w_error_nxt  = 1'b1;
            w_j_seen_nxt = 1'b0;
        end

`ifdef USB_RX_BUS_RESET_DET_EN
        if (w_bus_reset) begin
            w_state_nxt  = ST_IDLE;
            w_active_nxt = 1'b0;
            w_valid_nxt  = 1'b0;
            w_eop_nxt    = 1'b0;
            w_error_nxt  = 1'b0;
        end
`endif
    end

    assign rx_active = r_active;
    assign rx_valid  = r_valid;
    assign rx_data   = r_data;
    assign rx_eop    = r_eop;
    assign rx_error  = r_error;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: full-speed (4 clk/bit) and low-speed (8 clk/bit, 7/9 drift) instances.
// The bus-reset scenario runs when USB_RX_BUS_RESET_DET_EN is defined.
module tb_usb_rx_decoder;

    logic clk = 1'b0;
    logic reset;
    logic fs_p, fs_m, ls_p, ls_m;
    logic [1:0] fs_st, ls_st;
    logic fs_active, fs_valid, fs_eop, fs_err;
    logic ls_active, ls_valid, ls_eop, ls_err;
    logic [7:0] fs_data, ls_data;
`ifdef USB_RX_BUS_RESET_DET_EN
    logic fs_bus_reset, ls_bus_reset;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_rx_decoder #(.FULLSPEED(1), .CLKS_PER_BIT(4), .RESET_CLKS(120)) u_fs (
        .clk(clk), .reset(reset), .linep(fs_p), .linem(fs_m), .line_state(fs_st),
        .rx_active(fs_active), .rx_valid(fs_valid), .rx_data(fs_data), .rx_eop(fs_eop), .rx_error(fs_err)
`ifdef USB_RX_BUS_RESET_DET_EN
        , .bus_reset(fs_bus_reset)
`endif
    );

    usb_rx_decoder #(.FULLSPEED(0), .CLKS_PER_BIT(8), .RESET_CLKS(120)) u_ls (
        .clk(clk), .reset(reset), .linep(ls_p), .linem(ls_m), .line_state(ls_st),
        .rx_active(ls_active), .rx_valid(ls_valid), .rx_data(ls_data), .rx_eop(ls_eop), .rx_error(ls_err)
`ifdef USB_RX_BUS_RESET_DET_EN
        , .bus_reset(ls_bus_reset)
`endif
    );

    // Monitors: collect received bytes and strobe counts, flag protocol violations.
    logic [7:0] fs_bytes[$];
    logic [7:0] ls_bytes[$];
    int fs_eop_n = 0, fs_err_n = 0, fs_act_n = 0, fs_viol = 0;
    int ls_eop_n = 0, ls_err_n = 0, ls_act_n = 0, ls_viol = 0;
    logic fs_prev_strobe = 1'b0, ls_prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (fs_valid) fs_bytes.push_back(fs_data);
        if (fs_eop) fs_eop_n <= fs_eop_n + 1;
        if (fs_err) fs_err_n <= fs_err_n + 1;
        if (fs_active) fs_act_n <= fs_act_n + 1;
        if ((int'(fs_valid) + int'(fs_eop) + int'(fs_err)) > 1 || (fs_valid && !fs_active) ||
            ((fs_eop || fs_err) && fs_active) || (fs_prev_strobe && (fs_valid || fs_eop || fs_err)))
            fs_viol <= fs_viol + 1;
        fs_prev_strobe <= fs_valid || fs_eop || fs_err;
    end

    always @(negedge clk) begin
        if (ls_valid) ls_bytes.push_back(ls_data);
        if (ls_eop) ls_eop_n <= ls_eop_n + 1;
        if (ls_err) ls_err_n <= ls_err_n + 1;
        if (ls_active) ls_act_n <= ls_act_n + 1;
        if ((int'(ls_valid) + int'(ls_eop) + int'(ls_err)) > 1 || (ls_valid && !ls_active) ||
            ((ls_eop || ls_err) && ls_active) || (ls_prev_strobe && (ls_valid || ls_eop || ls_err)))
            ls_viol <= ls_viol + 1;
        ls_prev_strobe <= ls_valid || ls_eop || ls_err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: bytes -> SYNC + stuffed bits -> NRZI line symbols (0=J, 1=K, 2=SE0).
    logic [7:0] g_data[$];
    bit g_bits[$];
    int g_syms[$];
    bit g_ls_alt = 1'b0;
    int s_b, s_e, s_r, s_a;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ls, input int sym, input int clks);
        logic [1:0] mp;
        case (sym)
            0:       mp = ls ? 2'b10 : 2'b01;
            1:       mp = ls ? 2'b01 : 2'b10;
            default: mp = 2'b00;
        endcase
        if (ls) {ls_m, ls_p} = mp;
        else    {fs_m, fs_p} = mp;
        tick(clks);
    endtask

    task automatic send_sym(input bit ls, input int sym);
        int period;
        period = ls ? (g_ls_alt ? 9 : 7) : 4;
        if (ls) g_ls_alt = !g_ls_alt;
        drive(ls, sym, period);
    endtask

    task automatic idle(input bit ls, input int nbits);
        repeat (nbits) send_sym(ls, 0);
    endtask

    task automatic build_bits(input bit stuff);
        int ones;
        g_bits.delete();
        for (int i = 0; i < 7; i++) g_bits.push_back(1'b0);
        g_bits.push_back(1'b1);
        ones = 1;
        foreach (g_data[k]) begin
            for (int i = 0; i < 8; i++) begin
                g_bits.push_back(g_data[k][i]);
                if (g_data[k][i]) begin
                    ones++;
                    if (stuff && ones == 6) begin
                        g_bits.push_back(1'b0);
                        ones = 0;
                    end
                end else begin
                    ones = 0;
                end
            end
        end
    endtask

    task automatic nrzi_encode();
        int lvl;
        lvl = 0;
        g_syms.delete();
        foreach (g_bits[i]) begin
            if (!g_bits[i]) lvl = 1 - lvl;
            g_syms.push_back(lvl);
        end
        g_syms.push_back(2);
        g_syms.push_back(2);
    endtask

    task automatic play(input bit ls);
        foreach (g_syms[i]) send_sym(ls, g_syms[i]);
        idle(ls, 4);
    endtask

    task automatic take_snap(input bit ls);
        s_b = ls ? ls_bytes.size() : fs_bytes.size();
        s_e = ls ? ls_eop_n : fs_eop_n;
        s_r = ls ? ls_err_n : fs_err_n;
        s_a = ls ? ls_act_n : fs_act_n;
    endtask

    task automatic expect_counts(input bit ls, input string tag, input int eb, input int ee, input int er);
        check($sformatf("%s.nbytes", tag), (ls ? ls_bytes.size() : fs_bytes.size()) - s_b, eb);
        check($sformatf("%s.eop", tag), (ls ? ls_eop_n : fs_eop_n) - s_e, ee);
        check($sformatf("%s.error", tag), (ls ? ls_err_n : fs_err_n) - s_r, er);
        check($sformatf("%s.active_low", tag), ls ? ls_active : fs_active, 0);
    endtask

    task automatic send_good(input bit ls, input string tag);
        int nb;
        take_snap(ls);
        build_bits(1'b1);
        nrzi_encode();
        play(ls);
        expect_counts(ls, tag, g_data.size(), 1, 0);
        check($sformatf("%s.active_seen", tag), ((ls ? ls_act_n : fs_act_n) - s_a) > 0, 1);
        nb = (ls ? ls_bytes.size() : fs_bytes.size()) - s_b;
        for (int i = 0; i < g_data.size() && i < nb; i++)
            check($sformatf("%s.byte%0d", tag, i), ls ? ls_bytes[s_b + i] : fs_bytes[s_b + i], g_data[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'hFF;
        if (r == 1) return 8'h7F;
        return 8'($urandom);
    endfunction

    initial begin
        reset = 1'b1;
        {fs_m, fs_p} = 2'b01;
        {ls_m, ls_p} = 2'b10;
        #12;
        check("reset_fs_outputs", {fs_st, fs_active, fs_valid, fs_data, fs_eop, fs_err}, 0);
        check("reset_ls_outputs", {ls_st, ls_active, ls_valid, ls_data, ls_eop, ls_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(3);
        check("fs_line_state_j", fs_st, 2'b01);
        check("ls_line_state_j", ls_st, 2'b10);

        drive(0, 2, 1);
        check("line_state_lat1", fs_st, 2'b01);
        tick(1);
        check("line_state_lat2", fs_st, 2'b00);
        idle(0, 8);

        g_data = '{8'hA5};
        send_good(0, "byte_a5");

        g_data = '{8'hFF, 8'hFF};
        send_good(0, "stuff_ff");

        take_snap(0);
        build_bits(1'b0);
        nrzi_encode();
        play(0);
        expect_counts(0, "stuff_missing", 0, 0, 1);

        g_data = '{8'h5A};
        send_good(0, "recover");

        take_snap(0);
        send_sym(0, 1);
        send_sym(0, 0);
        send_sym(0, 0);
        idle(0, 4);
        expect_counts(0, "short_sync", 0, 0, 1);
        check("short_sync.no_active", fs_act_n - s_a, 0);

        take_snap(0);
        g_bits.delete();
        for (int i = 0; i < 7; i++) g_bits.push_back(1'b0);
        g_bits.push_back(1'b1);
        for (int i = 0; i < 5; i++) g_bits.push_back(1'($urandom));
        nrzi_encode();
        play(0);
        expect_counts(0, "misaligned_eop", 0, 0, 1);

        for (int p = 0; p < 6; p++) begin
            g_data.delete();
            repeat ($urandom_range(1, 4)) g_data.push_back(rand_byte());
            send_good(0, $sformatf("fs_rand%0d", p));
        end

        g_data = '{rand_byte(), rand_byte()};
        build_bits(1'b1);
        nrzi_encode();
        take_snap(0);
        for (int i = 0; i < 12; i++) send_sym(0, g_syms[i]);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", {fs_st, fs_active, fs_valid, fs_data, fs_eop, fs_err}, 0);
        {fs_m, fs_p} = 2'b01;
        tick(3);
        check("mid_reset_held", {fs_st, fs_active, fs_valid, fs_data, fs_eop, fs_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        idle(0, 10);
        expect_counts(0, "mid_reset_partial", 0, 0, 0);

        idle(1, 4);
        g_data = '{8'h01, 8'h80, 8'h3C};
        send_good(1, "ls_drift");
        for (int p = 0; p < 2; p++) begin
            g_data.delete();
            repeat ($urandom_range(1, 3)) g_data.push_back(rand_byte());
            send_good(1, $sformatf("ls_rand%0d", p));
        end

`ifdef USB_RX_BUS_RESET_DET_EN
        take_snap(0);
        {fs_m, fs_p} = 2'b00;
        tick(120);
        check("bus_reset_early", fs_bus_reset, 0);
        tick(10);
        check("bus_reset_high", fs_bus_reset, 1);
        check("bus_reset_ls_quiet", ls_bus_reset, 0);
        {fs_m, fs_p} = 2'b01;
        tick(1);
        check("bus_reset_hold", fs_bus_reset, 1);
        tick(3);
        check("bus_reset_release", fs_bus_reset, 0);
        idle(0, 4);
        expect_counts(0, "bus_reset_quiet", 0, 0, 0);
`endif

        check("fs_protocol_violations", fs_viol, 0);
        check("ls_protocol_violations", ls_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
